// File: rtl/ibex_imem_pkg.sv
// ============================================================================
// ibex_imem_pkg : shared types and limits for the instruction-memory responder
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ibex_imem_pkg;

    localparam int IMEM_MAX_LAT   = 4;
    localparam int IMEM_MAX_OUTST = 4;
    localparam int IMEM_IDX_W     = 30;

    typedef struct packed {
        logic [IMEM_IDX_W-1:0] idx;
        logic                  err;
        logic [1:0]            age;
    } imem_entry_t;

    function automatic logic [1:0] age_dec(input logic [1:0] age);
        return (age == 2'd0) ? 2'd0 : age - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_imem_resp_queue.sv
// ============================================================================
// ibex_imem_resp_queue : in-order circular FIFO of pending responses with ageing
// Revision             : 1.0
// ============================================================================
`default_nettype none

module ibex_imem_resp_queue
    import ibex_imem_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  imem_entry_t                push_entry_i,
    input  logic                       pop_i,
    output imem_entry_t                head_o,
    output logic                       head_ready_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    imem_entry_t       entries [Depth];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ages tick down every cycle; a freshly pushed entry overrides its slot
    // with the full initial age, which also covers a same-cycle pop/push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                entries[i].age <= age_dec(entries[i].age);
            end
            if (pop_i) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_i) begin
                entries[wr_ptr] <= push_entry_i;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_o       = entries[rd_ptr];
    assign head_ready_o = (count != '0) && (entries[rd_ptr].age == 2'd0);
    assign count_o      = count;

endmodule

`default_nettype wire

// File: rtl/ibex_instr_mem_responder.sv
// ============================================================================
// ibex_instr_mem_responder : word-array slave for the Ibex instruction fetch bus
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module ibex_instr_mem_responder
    import ibex_imem_pkg::*;
#(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int          MemWords       = 1024,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2,
    parameter int          GntStallPeriod = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        mem_we_i,
    input  logic [$clog2(MemWords)-1:0] mem_waddr_i,
    input  logic [31:0]                 mem_wdata_i
);

    localparam int         AW       = $clog2(MemWords);
    localparam int         CW       = $clog2(MaxOutstanding + 1);
    localparam logic [1:0] AGE_INIT = 2'(Latency - 1);

    if (Latency < 1 || Latency > IMEM_MAX_LAT) begin : g_bad_latency
        $error("ibex_instr_mem_responder: Latency out of range 1..4");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > IMEM_MAX_OUTST) begin : g_bad_outst
        $error("ibex_instr_mem_responder: MaxOutstanding out of range 1..4");
    end
    if (GntStallPeriod == 1 || GntStallPeriod < 0) begin : g_bad_stall
        $error("ibex_instr_mem_responder: GntStallPeriod must be 0 or >= 2");
    end
    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
        $error("ibex_instr_mem_responder: MemWords must be a power of two");
    end

    logic [31:0]   mem [MemWords];
    logic [31:0]   offset;
    logic          req_err;
    logic          stall;
    logic [31:0]   stall_cnt;
    logic          pop;
    logic          grant;
    imem_entry_t   push_entry;
    imem_entry_t   head;
    logic [CW-1:0] count;
    logic          unused_bits;

    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem[mem_waddr_i] <= mem_wdata_i;
        end
    end

    // Subtracting the base first makes "below base" and "past the end" two
    // independent checks on the raw address and on the offset word index.
    assign offset  = instr_addr_i - MemBase;
    assign req_err = (instr_addr_i < MemBase) || (offset[31:2] >= 30'(MemWords));

    assign stall = (GntStallPeriod != 0) && (stall_cnt == 32'(GntStallPeriod - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (instr_req_i && GntStallPeriod != 0) begin
            stall_cnt <= stall ? '0 : stall_cnt + 32'd1;
        end
    end

    assign grant = instr_req_i & ~rst_i & ~stall
                 & ((count < CW'(MaxOutstanding)) | pop);

    assign push_entry.idx = offset[31:2];
    assign push_entry.err = req_err;
    assign push_entry.age = AGE_INIT;

    ibex_imem_resp_queue #(
        .Depth (MaxOutstanding)
    ) u_resp_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (grant),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .head_ready_o (pop),
        .count_o      (count)
    );

    assign instr_gnt_o    = grant;
    assign instr_rvalid_o = pop;
    assign instr_err_o    = pop & head.err;
    assign instr_rdata_o  = (pop && !head.err) ? mem[head.idx[AW-1:0]] : 32'h0;

    assign unused_bits = ^{head.idx[IMEM_IDX_W-1:AW], head.age, offset[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_ibex_instr_mem_responder.sv
// ============================================================================
// tb_ibex_instr_mem_responder : directed vector bench over four configurations
// Revision                    : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [4];
    logic [31:0] addr  [4];
    logic        gnt   [4];
    logic        rv    [4];
    logic [31:0] rdata [4];
    logic        err   [4];
    logic        mem_we;
    logic [9:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: Latency 1   1: Latency 3   2: stall period 3   3: Latency 4, base 0x100
    ibex_instr_mem_responder #(.MemBase(32'h0), .MemWords(1024), .Latency(1),
        .MaxOutstanding(2), .GntStallPeriod(0)) u_l1 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rdata[0]),
        .instr_err_o(err[0]), .mem_we_i(mem_we), .mem_waddr_i(waddr), .mem_wdata_i(wdata));

    ibex_instr_mem_responder #(.MemBase(32'h0), .MemWords(1024), .Latency(3),
        .MaxOutstanding(2), .GntStallPeriod(0)) u_l3 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rdata[1]),
        .instr_err_o(err[1]), .mem_we_i(mem_we), .mem_waddr_i(waddr), .mem_wdata_i(wdata));

    ibex_instr_mem_responder #(.MemBase(32'h0), .MemWords(1024), .Latency(1),
        .MaxOutstanding(2), .GntStallPeriod(3)) u_st (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rdata[2]),
        .instr_err_o(err[2]), .mem_we_i(mem_we), .mem_waddr_i(waddr), .mem_wdata_i(wdata));

    ibex_instr_mem_responder #(.MemBase(32'h0000_0100), .MemWords(1024), .Latency(4),
        .MaxOutstanding(2), .GntStallPeriod(0)) u_l4 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
        .instr_gnt_o(gnt[3]), .instr_rvalid_o(rv[3]), .instr_rdata_o(rdata[3]),
        .instr_err_o(err[3]), .mem_we_i(mem_we), .mem_waddr_i(waddr), .mem_wdata_i(wdata));

    typedef struct {
        int          sel;
        logic        rq;
        logic [31:0] a;
        logic        g;
        logic        v;
        logic [31:0] d;
        logic        e;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input int sel, input logic rq, input logic [31:0] a,
                                input logic g, input logic v, input logic [31:0] d,
                                input logic e);
        vec_t x;
        x.sel = sel; x.rq = rq; x.a = a; x.g = g; x.v = v; x.d = d; x.e = e;
        vt.push_back(x);
    endfunction

    // One bus cycle: drive after the falling edge, settle, then sample.
    task automatic drive_cycle(input int sel, input logic rq, input logic [31:0] a);
        @(negedge clk);
        for (int i = 0; i < 4; i++) req[i] = 1'b0;
        req[sel]  = rq;
        addr[sel] = a;
        #1;
    endtask

    task automatic check_out(input string tag, input int sel, input logic g, input logic v,
                             input logic [31:0] d, input logic e);
        chk({tag, " gnt"},    32'(gnt[sel]), 32'(g));
        chk({tag, " rvalid"}, 32'(rv[sel]),  32'(v));
        chk({tag, " rdata"},  rdata[sel],    d);
        if (v) chk({tag, " err"}, 32'(err[sel]), 32'(e));
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        mem_we = 1'b1;
        waddr  = idx;
        wdata  = data;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        mem_we = 1'b0;
        waddr  = '0;
        wdata  = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]  = 1'b1;
            addr[i] = 32'h0000_0100;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset%0d gnt", i),    32'(gnt[i]), 32'd0);
            chk($sformatf("reset%0d rvalid", i), 32'(rv[i]),  32'd0);
            chk($sformatf("reset%0d rdata", i),  rdata[i],    32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req[i] = 1'b0;

        preload(10'd0, 32'h11);
        preload(10'd1, 32'h22);
        preload(10'd2, 32'h33);
        preload(10'd3, 32'h44);
        preload(10'd4, 32'hA5A5_0004);
        preload(10'd5, 32'h55);

        // Latency 1: back-to-back stream, then out-of-range and above-array errors
        add(0, 1, 32'h0,         1, 0, 32'h0,  0);
        add(0, 1, 32'h4,         1, 1, 32'h11, 0);
        add(0, 1, 32'h8,         1, 1, 32'h22, 0);
        add(0, 1, 32'hC,         1, 1, 32'h33, 0);
        add(0, 0, 32'h0,         0, 1, 32'h44, 0);
        add(0, 1, 32'h1000,      1, 0, 32'h0,  0);
        add(0, 1, 32'h10,        1, 1, 32'h0,  1);
        add(0, 0, 32'h0,         0, 1, 32'hA5A5_0004, 0);
        add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  0);
        add(0, 0, 32'h0,         0, 1, 32'h0,  1);
        add(0, 0, 32'h0,         0, 0, 32'h0,  0);
        // Latency 3, two outstanding: full stall, same-cycle pop regrant, latest addr wins
        add(1, 1, 32'h0,  1, 0, 32'h0,  0);
        add(1, 1, 32'h4,  1, 0, 32'h0,  0);
        add(1, 1, 32'h14, 0, 0, 32'h0,  0);
        add(1, 1, 32'h8,  1, 1, 32'h11, 0);
        add(1, 1, 32'hC,  1, 1, 32'h22, 0);
        add(1, 0, 32'h0,  0, 0, 32'h0,  0);
        add(1, 0, 32'h0,  0, 1, 32'h33, 0);
        add(1, 0, 32'h0,  0, 1, 32'h44, 0);
        add(1, 0, 32'h0,  0, 0, 32'h0,  0);
        // Stall period 3: pattern 1,1,0 and counter held while req is low
        add(2, 1, 32'h0, 1, 0, 32'h0,  0);
        add(2, 1, 32'h4, 1, 1, 32'h11, 0);
        add(2, 1, 32'h8, 0, 1, 32'h22, 0);
        add(2, 1, 32'h8, 1, 0, 32'h0,  0);
        add(2, 1, 32'hC, 1, 1, 32'h33, 0);
        add(2, 1, 32'h0, 0, 1, 32'h44, 0);
        add(2, 0, 32'h0, 0, 0, 32'h0,  0);
        add(2, 1, 32'h0, 1, 0, 32'h0,  0);
        add(2, 1, 32'h4, 1, 1, 32'h11, 0);
        add(2, 0, 32'h0, 0, 1, 32'h22, 0);
        add(2, 1, 32'h8, 0, 0, 32'h0,  0);
        add(2, 1, 32'h8, 1, 0, 32'h0,  0);
        add(2, 0, 32'h0, 0, 1, 32'h33, 0);
        add(2, 0, 32'h0, 0, 0, 32'h0,  0);
        // Latency 4, base 0x100: in-range word 0 then below-base error
        add(3, 1, 32'h100, 1, 0, 32'h0,  0);
        add(3, 1, 32'hFC,  1, 0, 32'h0,  0);
        add(3, 0, 32'h0,   0, 0, 32'h0,  0);
        add(3, 0, 32'h0,   0, 0, 32'h0,  0);
        add(3, 0, 32'h0,   0, 1, 32'h11, 0);
        add(3, 0, 32'h0,   0, 1, 32'h0,  1);
        add(3, 0, 32'h0,   0, 0, 32'h0,  0);

        for (int k = 0; k < vt.size(); k++) begin
            drive_cycle(vt[k].sel, vt[k].rq, vt[k].a);
            check_out($sformatf("vec%0d", k), vt[k].sel, vt[k].g, vt[k].v, vt[k].d, vt[k].e);
        end

        // Reset with two requests in flight discards them
        drive_cycle(3, 1, 32'h104);
        check_out("rst_pre0", 3, 1, 0, 32'h0, 0);
        drive_cycle(3, 1, 32'h108);
        check_out("rst_pre1", 3, 1, 0, 32'h0, 0);
        drive_cycle(3, 0, 32'h0);
        check_out("rst_pre2", 3, 0, 0, 32'h0, 0);
        rst    = 1'b1;
        req[3] = 1'b1;
        #1;
        check_out("rst_mid", 3, 0, 0, 32'h0, 0);
        chk("rst_mid err", 32'(err[3]), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        req[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_cycle(3, 0, 32'h0);
            check_out($sformatf("rst_post%0d", k), 3, 0, 0, 32'h0, 0);
        end
        drive_cycle(3, 1, 32'h108);
        check_out("rst_fetch", 3, 1, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(3, 0, 32'h0);
            check_out($sformatf("rst_wait%0d", k), 3, 0, 0, 32'h0, 0);
        end
        drive_cycle(3, 0, 32'h0);
        check_out("rst_resp", 3, 0, 1, 32'h33, 0);

        // Preload visibility around the rvalid cycle of word 5
        drive_cycle(0, 1, 32'h14);
        mem_we = 1'b1; waddr = 10'd5; wdata = 32'h66;
        check_out("pl_req0", 0, 1, 0, 32'h0, 0);
        drive_cycle(0, 0, 32'h0);
        mem_we = 1'b0;
        check_out("pl_new", 0, 0, 1, 32'h66, 0);
        drive_cycle(0, 1, 32'h14);
        check_out("pl_req1", 0, 1, 0, 32'h0, 0);
        drive_cycle(0, 0, 32'h0);
        mem_we = 1'b1; waddr = 10'd5; wdata = 32'h77;
        check_out("pl_old", 0, 0, 1, 32'h66, 0);
        drive_cycle(0, 1, 32'h14);
        mem_we = 1'b0;
        check_out("pl_req2", 0, 1, 0, 32'h0, 0);
        drive_cycle(0, 0, 32'h0);
        check_out("pl_after", 0, 0, 1, 32'h77, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
